// File: rtl/fifo_axis_packetizer.sv
// Drains a first-word-fall-through FIFO into an AXI4-Stream master, tlast every PKT_LEN beats.
// Define EASYOBV_FLUSH_EN to add head lookahead and a starvation timeout that closes partial packets.
module fifo_axis_packetizer #(
  parameter int DWIDTH  = 32,
  parameter int PKT_LEN = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] fifo_rd_data,
  input  logic              fifo_rd_empty,
  output logic              fifo_rd_en,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  localparam int CNT_W = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

  logic [DWIDTH-1:0] hold_data_r;
  logic              hold_valid_r;
  logic [CNT_W-1:0]  beat_cnt_r;
  logic              at_end_s;
  logic              hs_s;
  logic              pop_s;
  logic              tvalid_s;
  logic              tlast_s;

`ifdef EASYOBV_FLUSH_EN
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_cnt_r;
  logic              flush_pending_r;
  logic              idle_inc_s;
`endif

  // Handshake, pop and stream-qualifier decode
  always_comb begin
    at_end_s = (beat_cnt_r == LAST_BEAT);
`ifdef EASYOBV_FLUSH_EN
    // Only present a beat when its packet position is known: more data queued, last beat, or flushed.
    tvalid_s   = hold_valid_r & (~fifo_rd_empty | at_end_s | flush_pending_r);
    tlast_s    = at_end_s | flush_pending_r;
    idle_inc_s = hold_valid_r & fifo_rd_empty & ~at_end_s & ~flush_pending_r;
`else
    tvalid_s = hold_valid_r;
    tlast_s  = at_end_s;
`endif
    hs_s  = tvalid_s & m_axis_tready;
    pop_s = ~rst & ~fifo_rd_empty & (~hold_valid_r | hs_s);
  end

  // Hold register and packet beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data_r  <= '0;
      hold_valid_r <= 1'b0;
      beat_cnt_r   <= '0;
    end else begin
      if (pop_s) begin
        hold_data_r  <= fifo_rd_data;
        hold_valid_r <= 1'b1;
      end else if (hs_s) begin
        hold_valid_r <= 1'b0;
      end
      if (hs_s) begin
        beat_cnt_r <= tlast_s ? '0 : beat_cnt_r + CNT_W'(1);
      end
    end
  end

`ifdef EASYOBV_FLUSH_EN
  // Starvation timer; flush stays latched until the flushed beat is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_r      <= '0;
      flush_pending_r <= 1'b0;
    end else begin
      if (idle_inc_s) begin
        idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
      end else begin
        idle_cnt_r <= '0;
      end
      if (hs_s) begin
        flush_pending_r <= 1'b0;
      end else if (idle_inc_s && (idle_cnt_r == IDLE_LAST)) begin
        flush_pending_r <= 1'b1;
      end
    end
  end
`endif

  assign fifo_rd_en    = pop_s;
  assign m_axis_tdata  = hold_data_r;
  assign m_axis_tvalid = tvalid_s;
  assign m_axis_tlast  = tlast_s;

endmodule

// File: tb/tb_fifo_axis_packetizer.sv
// Directed bench for fifo_axis_packetizer (PKT_LEN=4, TIMEOUT=5); expectations follow EASYOBV_FLUSH_EN.
module tb_fifo_axis_packetizer;

  localparam int DW = 32;
`ifdef EASYOBV_FLUSH_EN
  localparam logic FLUSH = 1'b1;
`else
  localparam logic FLUSH = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // FIFO model: FWFT head, popped by the DUT, filled by the stimulus
  logic [DW-1:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } beat_t;
  beat_t beats[$];
  beat_t pops[$];

  fifo_axis_packetizer #(.DWIDTH(DW), .PKT_LEN(4), .TIMEOUT(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_empty (fifo_rd_empty),
    .fifo_rd_en    (fifo_rd_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign fifo_rd_empty = (rd_ptr == wr_ptr);
  assign fifo_rd_data  = mem[rd_ptr[7:0]];

  always @(posedge clk) begin
    if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
  end

  // Record accepted beats and pops between edges
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready)
      beats.push_back(beat_t'{m_axis_tdata, m_axis_tlast, cyc});
    if (fifo_rd_en)
      pops.push_back(beat_t'{fifo_rd_data, 1'b0, cyc});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst = 1'b1;
    m_axis_tready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    beats.delete();
    pops.delete();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (beats.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("beat_count", beats.size(), n);
  endtask

  task automatic check_beat(input int i, input logic [DW-1:0] d, input logic l);
    if (i < beats.size()) begin
      chk($sformatf("beat%0d_data", i), beats[i].data, d);
      chk($sformatf("beat%0d_last", i), beats[i].last, l);
    end else begin
      chk($sformatf("beat%0d_present", i), beats.size(), i + 1);
    end
  endtask

  initial begin
    logic [3:0] pat;
    logic       exp_l [6];
    int         pb;

    // Reset held with the FIFO non-empty
    push(32'h55);
    repeat (3) begin
      @(negedge clk);
      chk("rst_rd_en", fifo_rd_en, 1'b0);
      chk("rst_tvalid", m_axis_tvalid, 1'b0);
      chk("rst_tlast", m_axis_tlast, 1'b0);
      chk("rst_tdata", m_axis_tdata, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("first_pop", fifo_rd_en, 1'b1);
    @(negedge clk);
    chk("first_tdata", m_axis_tdata, 32'h55);
    chk("first_tvalid", m_axis_tvalid, FLUSH ? 1'b0 : 1'b1);
    reset_pulse();
    @(negedge clk);
    chk("midrst_tvalid", m_axis_tvalid, 1'b0);
    chk("midrst_tdata", m_axis_tdata, 32'h0);
    chk("midrst_rd_en", fifo_rd_en, 1'b0);

    // Two full packets at one beat per cycle
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    wait_beats(8, 40);
    for (int i = 0; i < 8; i++) check_beat(i, DW'(i + 1), (i == 3) || (i == 7));
    if (beats.size() >= 8) chk("no_bubble", beats[7].cyc - beats[0].cyc, 32'd7);
    reset_pulse();

    // Back-pressure: tready 1,0,0,1 over a 6-word burst
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) push(DW'(32'h21 + i));
    @(posedge clk); #1;
    pat = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      m_axis_tready = pat[k];
      @(negedge clk);
      if (!pat[k]) begin
        chk("stall_tvalid", m_axis_tvalid, 1'b1);
        chk("stall_tdata", m_axis_tdata, 32'h22);
        chk("stall_tlast", m_axis_tlast, 1'b0);
        chk("stall_rd_en", fifo_rd_en, 1'b0);
      end
      @(posedge clk); #1;
    end
    m_axis_tready = 1'b1;
    wait_beats(6, 40);
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FLUSH};
    for (int i = 0; i < 6; i++) check_beat(i, DW'(32'h21 + i), exp_l[i]);
    reset_pulse();

    // Starvation after two words, then four more words
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    push(32'hA);
    push(32'hB);
    wait_beats(2, 30);
    check_beat(0, 32'hA, 1'b0);
    check_beat(1, 32'hB, FLUSH);
    pb = -100;
    foreach (pops[j]) if (pops[j].data == 32'hB) pb = pops[j].cyc;
    if (beats.size() >= 2) chk("flush_latency", beats[1].cyc - pb, FLUSH ? 32'd6 : 32'd1);
    for (int i = 0; i < 4; i++) push(DW'(32'hC1 + i));
    wait_beats(6, 30);
    exp_l = '{1'b0, 1'b0, 1'b0, FLUSH ? 1'b0 : 1'b1, 1'b0, FLUSH};
    for (int i = 0; i < 4; i++) check_beat(i + 2, DW'(32'hC1 + i), exp_l[i + 2]);
    reset_pulse();

    // Flush raised while stalled, then more data arrives before acceptance
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    push(32'hA);
    push(32'hB);
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_axis_tready = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("latch_tvalid", m_axis_tvalid, 1'b1);
    chk("latch_tlast", m_axis_tlast, FLUSH);
    chk("latch_tdata", m_axis_tdata, 32'hB);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push(DW'(32'hC + i));
    @(negedge clk);
    chk("latch_hold_tlast", m_axis_tlast, FLUSH);
    chk("latch_hold_tdata", m_axis_tdata, 32'hB);
    chk("latch_hold_rd_en", fifo_rd_en, 1'b0);
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    wait_beats(6, 40);
    exp_l = '{1'b0, FLUSH, 1'b0, FLUSH ? 1'b0 : 1'b1, 1'b0, FLUSH};
    check_beat(0, 32'hA, exp_l[0]);
    check_beat(1, 32'hB, exp_l[1]);
    for (int i = 0; i < 4; i++) check_beat(i + 2, DW'(32'hC + i), exp_l[i + 2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
